// File: rtl/dwb_pkg.sv
// Shared types and constants for the write-through data write buffer.
package dwb_pkg;

   localparam int WORD_LSB = 2;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } state_t;

   // Reference layout of one buffered store at the default 32-bit widths.
   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } entry_t;

endpackage

// File: rtl/dwb_fifo.sv
// Circular store buffer with a youngest-entry address lookup for read forwarding.
module dwb_fifo
   import dwb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 30,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data,
   input  logic [AW-1:0] lookup_addr,
   output logic          hit,
   output logic [DW-1:0] hit_data
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] count;
   logic [IDX_W-1:0] idx;

   assign count     = wr_ptr - rd_ptr;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                      (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
   assign head_addr = addr_q[rd_ptr[IDX_W-1:0]];
   assign head_data = data_q[rd_ptr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         addr_q[wr_ptr[IDX_W-1:0]] <= push_addr;
         data_q[wr_ptr[IDX_W-1:0]] <= push_data;
      end
   end

   // Walk oldest to youngest so the last match seen is the newest store.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr[IDX_W-1:0] + IDX_W'(k);
         if ((PTR_W'(k) < count) && (addr_q[idx] == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

endmodule

// File: rtl/data_write_buffer.sv
// Write-through store buffer between data cache and memory: drains stores, serves read misses, forwards buffered data.
module data_write_buffer
   import dwb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic              rd_resp_valid,
   output logic [DATA_W-1:0] rd_resp_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int AW = ADDR_W - WORD_LSB;

   state_t            state;
   logic              full;
   logic              empty;
   logic              hit;
   logic              push;
   logic              pop;
   logic              rd_accept;
   logic [AW-1:0]     head_addr;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] hit_data;
   logic              unused_offset;

   assign unused_offset = ^wr_addr[WORD_LSB-1:0];

   assign wr_ready  = rst_n && !full;
   assign rd_ready  = rst_n && (state == IDLE);
   assign push      = wr_valid && wr_ready;
   assign rd_accept = rd_valid && rd_ready;
   assign pop       = (state == WRITE) && mem_ack;

   dwb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_addr   (wr_addr[ADDR_W-1:WORD_LSB]),
      .push_data   (wr_data),
      .pop         (pop),
      .full        (full),
      .empty       (empty),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .lookup_addr (rd_addr[ADDR_W-1:WORD_LSB]),
      .hit         (hit),
      .hit_data    (hit_data)
   );

   // Reads win over draining; a buffered match is answered without touching memory.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         rd_resp_valid <= 1'b0;
         rd_resp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_accept) begin
                  if (hit) begin
                     rd_resp_data  <= hit_data;
                     rd_resp_valid <= 1'b1;
                     state         <= RESP;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= rd_addr;
                     state    <= READ;
                  end
               end else if (!empty) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {head_addr, {WORD_LSB{1'b0}}};
                  mem_wdata <= head_data;
                  state     <= WRITE;
               end
            end
            READ: begin
               if (mem_ack) begin
                  mem_req       <= 1'b0;
                  rd_resp_data  <= mem_rdata;
                  rd_resp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= IDLE;
               end
            end
            RESP: begin
               rd_resp_valid <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed self-checking bench for data_write_buffer; the bench plays the memory side.
module tb_data_write_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_valid;
   logic [31:0] rd_addr;
   logic        rd_ready;
   logic        rd_resp_valid;
   logic [31:0] rd_resp_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_write_buffer #(
      .DEPTH  (4),
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .rd_valid      (rd_valid),
      .rd_addr       (rd_addr),
      .rd_ready      (rd_ready),
      .rd_resp_valid (rd_resp_valid),
      .rd_resp_data  (rd_resp_data),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   // Bounded wait for mem_req; caller judges the result. Starts and ends on a negedge.
   task automatic wait_req(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_req === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_ready, rd_ready, rd_resp_valid, mem_req, mem_we} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {wr_ready, rd_ready, rd_resp_valid, mem_req, mem_we});
      end
      checks++;
      if ({mem_addr, mem_wdata, rd_resp_data} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h expected zeros", mem_addr, mem_wdata, rd_resp_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({wr_ready, rd_ready, mem_req} !== 3'b110) begin
         errors++;
         $display("FAIL post_reset: got %b expected 110", {wr_ready, rd_ready, mem_req});
      end
   endtask

   task automatic test_single_write();
      wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hAAAA0001;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'hAAAA0001}) begin
         errors++;
         $display("FAIL single_req: got %b%b %h %h expected 11 00000100 aaaa0001", mem_req, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
         errors++;
         $display("FAIL single_hold: got %b %h expected 1 00000100", mem_req, mem_addr);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL single_drop: got %b expected 0", mem_req);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_req, wr_ready} !== 2'b01) begin
         errors++;
         $display("FAIL single_empty: got %b expected 01", {mem_req, wr_ready});
      end
   endtask

   task automatic test_fill_full();
      bit found;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_addr = 32'h10 + 32'(4 * i); wr_data = 32'hB0000000 + 32'(i);
         @(negedge clk);
      end
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: got %b expected 0", wr_ready);
      end
      wr_addr = 32'h20; wr_data = 32'h00000BAD;
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_ready, mem_req, mem_addr} !== {2'b01, 32'h10}) begin
         errors++;
         $display("FAIL full_hold: got %b%b %h expected 01 00000010", wr_ready, mem_req, mem_addr);
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_req(found);
         checks++;
         if (!found || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h10 + 32'(4 * i), 32'hB0000000 + 32'(i)}) begin
            errors++;
            $display("FAIL full_drain%0d: got req=%b we=%b %h %h expected 1 1 %h %h", i, found, mem_we, mem_addr,
                     mem_wdata, 32'h10 + 32'(4 * i), 32'hB0000000 + 32'(i));
         end
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_req, wr_ready} !== 2'b01) begin
         errors++;
         $display("FAIL full_after: got %b expected 01", {mem_req, wr_ready});
      end
   endtask

   task automatic test_forward();
      bit found;
      rd_valid = 1'b1; rd_addr = 32'h300;
      @(negedge clk);
      rd_valid = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h300}) begin
         errors++;
         $display("FAIL fwd_miss_req: got %b%b %h expected 10 00000300", mem_req, mem_we, mem_addr);
      end
      wr_valid = 1'b1; wr_addr = 32'h40; wr_data = 32'h11;
      @(negedge clk);
      wr_data = 32'h22;
      @(negedge clk);
      wr_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({rd_resp_valid, rd_resp_data} !== {1'b1, 32'h12345678}) begin
         errors++;
         $display("FAIL fwd_miss_resp: got %b %h expected 1 12345678", rd_resp_valid, rd_resp_data);
      end
      rd_valid = 1'b1; rd_addr = 32'h42;
      @(negedge clk);
      checks++;
      if (rd_ready !== 1'b1) begin
         errors++;
         $display("FAIL fwd_rd_ready: got %b expected 1", rd_ready);
      end
      @(negedge clk);
      rd_valid = 1'b0;
      checks++;
      if ({rd_resp_valid, rd_resp_data, mem_req} !== {1'b1, 32'h22, 1'b0}) begin
         errors++;
         $display("FAIL fwd_hit: got %b %h req=%b expected 1 00000022 req=0", rd_resp_valid, rd_resp_data, mem_req);
      end
      @(negedge clk);
      checks++;
      if (rd_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL fwd_pulse: got %b expected 0", rd_resp_valid);
      end
      for (int i = 0; i < 2; i++) begin
         wait_req(found);
         checks++;
         if (!found || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h40, (i == 0) ? 32'h11 : 32'h22}) begin
            errors++;
            $display("FAIL fwd_drain%0d: got req=%b we=%b %h %h", i, found, mem_we, mem_addr, mem_wdata);
         end
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
      end
   endtask

   task automatic test_read_bypass();
      bit found;
      wr_valid = 1'b1; wr_addr = 32'h80; wr_data = 32'h55;
      @(negedge clk);
      wr_valid = 1'b0;
      rd_valid = 1'b1; rd_addr = 32'h200;
      @(negedge clk);
      rd_valid = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h200}) begin
         errors++;
         $display("FAIL bypass_req: got %b%b %h expected 10 00000200", mem_req, mem_we, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({rd_resp_valid, rd_resp_data, mem_req} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
         errors++;
         $display("FAIL bypass_resp: got %b %h req=%b expected 1 deadbeef req=0", rd_resp_valid, rd_resp_data, mem_req);
      end
      wait_req(found);
      checks++;
      if (!found || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h80, 32'h55}) begin
         errors++;
         $display("FAIL bypass_drain: got req=%b we=%b %h %h expected 1 1 00000080 00000055", found, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   task automatic test_same_cycle();
      bit found;
      wr_valid = 1'b1; wr_addr = 32'h60; wr_data = 32'h5;
      rd_valid = 1'b1; rd_addr = 32'h60;
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h60}) begin
         errors++;
         $display("FAIL same_req: got %b%b %h expected 10 00000060", mem_req, mem_we, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'hCAFE0060;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({rd_resp_valid, rd_resp_data} !== {1'b1, 32'hCAFE0060}) begin
         errors++;
         $display("FAIL same_resp: got %b %h expected 1 cafe0060", rd_resp_valid, rd_resp_data);
      end
      wait_req(found);
      checks++;
      if (!found || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h60, 32'h5}) begin
         errors++;
         $display("FAIL same_drain: got req=%b we=%b %h %h expected 1 1 00000060 00000005", found, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit found;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_addr = 32'hA0 + 32'(4 * i); wr_data = 32'(i + 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'hA0}) begin
         errors++;
         $display("FAIL rmid_busy: got %b%b %h expected 11 000000a0", mem_req, mem_we, mem_addr);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req, rd_resp_valid, wr_ready} !== 3'b000) begin
         errors++;
         $display("FAIL rmid_reset: got %b expected 000", {mem_req, rd_resp_valid, wr_ready});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmid_ready: got %b expected 1", wr_ready);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({mem_req, rd_resp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL rmid_flushed: got %b expected 00", {mem_req, rd_resp_valid});
      end
      wr_valid = 1'b1; wr_addr = 32'hC0; wr_data = 32'h77;
      @(negedge clk);
      wr_valid = 1'b0;
      wait_req(found);
      checks++;
      if (!found || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'hC0, 32'h77}) begin
         errors++;
         $display("FAIL rmid_next: got req=%b we=%b %h %h expected 1 1 000000c0 00000077", found, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      test_reset();
      test_single_write();
      test_fill_full();
      test_forward();
      test_read_bypass();
      test_same_cycle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
